// File: rtl/mux_pkg.sv
// Shared types and the round-robin pick function for the mux41 control path.
package mux_pkg;

  localparam int N_SRC = 4;

  typedef logic [1:0] sel_t;
  typedef logic [N_SRC-1:0] req_t;

  // First index at or after ptr (mod 4) with req set; ptr if none.
  // The loop runs backwards so the earliest index in search order wins.
  function automatic sel_t rr_pick(req_t req, sel_t ptr);
    sel_t idx;
    rr_pick = ptr;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = ptr + sel_t'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way priority rotate: chosen requester and any-request flag.
module rr_pick4
  import mux_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] chosen,
  output logic       any_req
);

  always_comb begin
    chosen  = rr_pick(req, ptr);
    any_req = |req;
  end

endmodule

// File: rtl/mux41_rr_ctrl.sv
// Round-robin select driver for the 4:1 mux with a single-entry valid/ready capture stage.
module mux41_rr_ctrl
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       grant,
  output logic [1:0]       select,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  sel_t             ptr_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  sel_t chosen;
  logic any_req;
  logic space;
  logic load;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .chosen  (chosen),
    .any_req (any_req)
  );

  // A full stage being drained this edge can accept a new capture at once.
  always_comb begin
    space  = !valid_q || dout_ready;
    load   = space && any_req && rst_n;
    select = 2'b00;
    if (rst_n) select = any_req ? chosen : ptr_q;
    grant  = load ? (req_t'(1) << chosen) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      dout_q  <= mux_out;
      valid_q <= 1'b1;
      ptr_q   <= chosen + 2'd1;
      cnt_q   <= cnt_q + CNT_W'(1);
    end else if (valid_q && dout_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign xfer_cnt   = cnt_q;

endmodule

// File: tb/tb_mux41_rr_ctrl.sv
// Directed bench for mux41_rr_ctrl; a second instance with CNT_W=2 checks counter wrap.
module tb_mux41_rr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       dout_ready;
  logic [3:0] grant, grant2;
  logic [1:0] select, select2;
  logic [3:0] mux_out, mux_out2;
  logic [3:0] dout, dout2;
  logic       dout_valid, dout_valid2;
  logic [7:0] xfer_cnt;
  logic [1:0] xfer_cnt2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] mux_data(logic [1:0] s);
    case (s)
      2'd0:    return 4'b1001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  assign mux_out  = mux_data(select);
  assign mux_out2 = mux_data(select2);

  mux41_rr_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant      (grant),
    .select     (select),
    .mux_out    (mux_out),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .xfer_cnt   (xfer_cnt)
  );

  mux41_rr_ctrl #(.WIDTH(4), .CNT_W(2)) dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant      (grant2),
    .select     (select2),
    .mux_out    (mux_out2),
    .dout       (dout2),
    .dout_valid (dout_valid2),
    .dout_ready (dout_ready),
    .xfer_cnt   (xfer_cnt2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: check combinational outputs before the edge, registers after.
  task automatic step(input string tag, input logic rst, input logic [3:0] r, input logic rdy,
                      input logic [3:0] e_grant, input logic [1:0] e_sel,
                      input logic [3:0] e_dout, input logic e_valid, input logic [7:0] e_cnt);
    @(negedge clk);
    rst_n      = rst;
    req        = r;
    dout_ready = rdy;
    #1;
    check_eq({tag, ".grant"}, 32'(grant), 32'(e_grant));
    check_eq({tag, ".select"}, 32'(select), 32'(e_sel));
    @(posedge clk);
    #1;
    check_eq({tag, ".dout"}, 32'(dout), 32'(e_dout));
    check_eq({tag, ".valid"}, 32'(dout_valid), 32'(e_valid));
    check_eq({tag, ".cnt"}, 32'(xfer_cnt), 32'(e_cnt));
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = 4'b1111;
    dout_ready = 1'b1;

    // Reset held with all requests pending
    step("rst0", 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 8'd0);
    step("rst1", 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 8'd0);
    check_eq("rst.cnt_w", 32'(xfer_cnt2), 32'd0);

    // Round robin, full request, consumer always ready
    step("rr0", 1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'b1001, 1'b1, 8'd1);
    check_eq("wrap1", 32'(xfer_cnt2), 32'd1);
    step("rr1", 1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 4'b0011, 1'b1, 8'd2);
    check_eq("wrap2", 32'(xfer_cnt2), 32'd2);
    step("rr2", 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 4'b0111, 1'b1, 8'd3);
    check_eq("wrap3", 32'(xfer_cnt2), 32'd3);
    step("rr3", 1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 4'b1111, 1'b1, 8'd4);
    check_eq("wrap0", 32'(xfer_cnt2), 32'd0);
    step("rr4", 1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'b1001, 1'b1, 8'd5);
    check_eq("wrap1b", 32'(xfer_cnt2), 32'd1);

    // Reset while full discards the held data
    step("rstmid", 1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 8'd0);

    // Sparse requests from ptr=0: index 0 never chosen
    step("sp0", 1'b1, 4'b1010, 1'b1, 4'b0010, 2'd1, 4'b0011, 1'b1, 8'd1);
    step("sp1", 1'b1, 4'b1010, 1'b1, 4'b1000, 2'd3, 4'b1111, 1'b1, 8'd2);
    step("sp2", 1'b1, 4'b1010, 1'b1, 4'b0010, 2'd1, 4'b0011, 1'b1, 8'd3);

    // Backpressure: ptr=2, stage full, consumer stalled
    step("bp0", 1'b1, 4'b0100, 1'b0, 4'b0000, 2'd2, 4'b0011, 1'b1, 8'd3);
    step("bp1", 1'b1, 4'b0100, 1'b0, 4'b0000, 2'd2, 4'b0011, 1'b1, 8'd3);
    step("bp2", 1'b1, 4'b0100, 1'b0, 4'b0000, 2'd2, 4'b0011, 1'b1, 8'd3);
    step("bp3", 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0111, 1'b1, 8'd4);

    // Single requester is granted every cycle
    step("one0", 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0111, 1'b1, 8'd5);

    // One transfer from index 0 (ptr=3 wraps), then idle drain
    step("dr0", 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b1001, 1'b1, 8'd6);
    step("dr1", 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd1, 4'b1001, 1'b0, 8'd6);
    step("dr2", 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd1, 4'b1001, 1'b0, 8'd6);

    // Empty stage accepts even with dout_ready low
    step("emp0", 1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 4'b1111, 1'b1, 8'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
